btn_word_loader: RTL and testbench

BTN_WORD_LOADER -- requirements
Module: btn_word_loader

---
 rtl/btn_loader_pkg.sv | 12 +
 rtl/btn_sync_edge.sv | 40 ++++
 rtl/btn_word_loader.sv | 100 ++++++++++
 tb/tb_btn_word_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_loader_pkg.sv
// rtl/btn_loader_pkg.sv - shared loader state encoding and button indices
package btn_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FULL, SEND} state_t;

  localparam int BTN_W      = 4;
  localparam int BTN_ZERO   = 0;
  localparam int BTN_ONE    = 1;
  localparam int BTN_COMMIT = 2;
  localparam int BTN_CLEAR  = 3;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - per-bit synchronizer chain with rising-edge pulse output
module btn_sync_edge #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0]            primed_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  armed_q;
  logic [WIDTH-1:0]                  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A bit only arms once a genuinely sampled low has reached the chain end,
  // so a button held through reset release cannot fire until it is re-pressed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      primed_q <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      prev_q   <= sync_last;
      if (primed_q[SYNC_STAGES-1]) begin
        armed_q <= armed_q | ~sync_last;
      end
    end
  end

  assign rise_o = sync_last & ~prev_q & armed_q;

endmodule

// File: rtl/btn_word_loader.sv
// rtl/btn_word_loader.sv - assembles a word from shift-0/shift-1 buttons and hands it downstream
module btn_word_loader
  import btn_loader_pkg::*;
#(
  parameter int DATA_W      = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  btn,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(DATA_W+1)-1:0] bit_cnt,
  output logic                        err
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [BTN_W-1:0]  ev;
  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [DATA_W-1:0] m_data_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              m_valid_q;
  logic              err_q;
  logic              bit_ev;
  logic              bit_clash;
  logic              last_bit;
  logic              is_full;

  btn_sync_edge #(
    .WIDTH       (BTN_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (btn),
    .rise_o (ev)
  );

  assign bit_clash = ev[BTN_ZERO] & ev[BTN_ONE];
  assign bit_ev    = ev[BTN_ZERO] ^ ev[BTN_ONE];
  assign shreg_d   = {shreg_q[DATA_W-2:0], ev[BTN_ONE]};
  assign cnt_d     = cnt_q + CW'(1);
  assign last_bit  = (cnt_q == CW'(DATA_W - 1));
  assign is_full   = (state_q == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        SEND: begin
          if (m_ready) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          if (ev[BTN_CLEAR]) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
          end else begin
            // A bit and a commit in one cycle are judged against the pre-cycle state.
            err_q <= bit_clash | (bit_ev & is_full) | (ev[BTN_COMMIT] & ~is_full);
            if (bit_ev && !is_full) begin
              shreg_q <= shreg_d;
              cnt_q   <= cnt_d;
              state_q <= last_bit ? FULL : LOAD;
            end
            if (ev[BTN_COMMIT] && is_full) begin
              state_q   <= SEND;
              m_valid_q <= 1'b1;
              m_data_q  <= shreg_q;
            end
          end
        end
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign bit_cnt = cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_btn_word_loader.sv
// tb/tb_btn_word_loader.sv - randomized self-checking bench for btn_word_loader
module tb_btn_word_loader;

  localparam int W = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    btn = '0;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic [5:0]    bit_cnt;
  logic          err;

  int total = 0;
  int bad   = 0;

  int           m_cnt;
  logic [W-1:0] m_word;
  bit           m_send;

  btn_word_loader #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .bit_cnt (bit_cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_cnt  = 0;
    m_word = '0;
    m_send = 1'b0;
  endfunction

  // Expected reaction to one button event; returns whether it must be rejected.
  function automatic bit model_step(input logic [3:0] mask);
    bit full;
    bit e;
    if (m_send) return 1'b0;
    if (mask[3]) begin
      model_reset();
      return 1'b0;
    end
    full = (m_cnt == W);
    e = 1'b0;
    if (mask[0] && mask[1]) e = 1'b1;
    else if (mask[0] || mask[1]) begin
      if (full) e = 1'b1;
      else begin
        m_word = m_word * 2 + W'(mask[1]);
        m_cnt  = m_cnt + 1;
      end
    end
    if (mask[2]) begin
      if (full) m_send = 1'b1;
      else e = 1'b1;
    end
    return e;
  endfunction

  // One-cycle pulse; returns at the sample point where its effect is first visible.
  task automatic press(input logic [3:0] mask);
    @(negedge clk) btn = mask;
    @(negedge clk) btn = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_random(input int n);
    logic [3:0] m;
    for (int i = 0; i < n; i++) begin
      m = ($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b0001;
      press(m);
      void'(model_step(m));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || bit_cnt !== 6'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%b data=%h cnt=%0d err=%b, want all zero", m_valid, m_data, bit_cnt, err);
    end
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [W-1:0] pat;
    logic [3:0]   m;
    bit           e;
    pat = 48'hFFFF_FFFF_FF00;
    m_ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      m = pat[W-1-i] ? 4'b0010 : 4'b0001;
      press(m);
      e = model_step(m);
      total++;
      if (err !== e || bit_cnt !== 6'(m_cnt)) begin
        bad++;
        $display("FAIL full_word_load[%0d]: err=%b cnt=%0d, want err=%b cnt=%0d", i, err, bit_cnt, e, m_cnt);
      end
    end
    press(4'b0100);
    e = model_step(4'b0100);
    total++;
    if (m_valid !== 1'b1 || m_data !== pat || err !== e) begin
      bad++;
      $display("FAIL full_word_send: valid=%b data=%h err=%b, want 1 %h %b", m_valid, m_data, err, pat, e);
    end
    @(negedge clk);
    model_reset();
    total++;
    if (m_valid !== 1'b0 || bit_cnt !== 6'd0 || m_data !== '0) begin
      bad++;
      $display("FAIL full_word_after: valid=%b cnt=%0d data=%h, want 0 0 0", m_valid, bit_cnt, m_data);
    end
  endtask

  task automatic test_early_commit();
    bit e;
    m_ready = 1'b1;
    load_random(20);
    press(4'b0100);
    e = model_step(4'b0100);
    total++;
    if (err !== e || e !== 1'b1) begin
      bad++;
      $display("FAIL early_commit_err: err=%b, want 1", err);
    end
    total++;
    if (bit_cnt !== 6'd20 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_commit_state: cnt=%0d valid=%b, want 20 0", bit_cnt, m_valid);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL early_commit_pulse: err=%b one cycle later, want 0", err);
    end
    press(4'b1000);
    void'(model_step(4'b1000));
  endtask

  task automatic test_overflow_hold();
    bit e;
    m_ready = 1'b0;
    load_random(W);
    press(4'b0010);
    e = model_step(4'b0010);
    total++;
    if (err !== 1'b1 || e !== 1'b1 || bit_cnt !== 6'd48) begin
      bad++;
      $display("FAIL overflow_bit: err=%b cnt=%0d, want 1 48", err, bit_cnt);
    end
    press(4'b0100);
    void'(model_step(4'b0100));
    for (int k = 0; k < 5; k++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== m_word) begin
        bad++;
        $display("FAIL hold[%0d]: valid=%b data=%h, want 1 %h", k, m_valid, m_data, m_word);
      end
      if (k < 4) @(negedge clk);
    end
    press(4'b0001);
    e = model_step(4'b0001);
    total++;
    if (err !== e || m_valid !== 1'b1 || bit_cnt !== 6'd48 || m_data !== m_word) begin
      bad++;
      $display("FAIL send_ignore: err=%b valid=%b cnt=%0d data=%h, want 0 1 48 %h", err, m_valid, bit_cnt, m_data, m_word);
    end
    m_ready = 1'b1;
    @(negedge clk);
    model_reset();
    total++;
    if (m_valid !== 1'b0 || bit_cnt !== 6'd0 || m_data !== '0) begin
      bad++;
      $display("FAIL hold_handshake: valid=%b cnt=%0d data=%h, want 0 0 0", m_valid, bit_cnt, m_data);
    end
  endtask

  task automatic test_pair_and_clear();
    bit e;
    m_ready = 1'b1;
    load_random(7);
    press(4'b0011);
    e = model_step(4'b0011);
    total++;
    if (err !== 1'b1 || e !== 1'b1 || bit_cnt !== 6'd7) begin
      bad++;
      $display("FAIL pair_clash: err=%b cnt=%0d, want 1 7", err, bit_cnt);
    end
    load_random(23);
    total++;
    if (bit_cnt !== 6'd30) begin
      bad++;
      $display("FAIL pair_reload: cnt=%0d, want 30", bit_cnt);
    end
    press(4'b1010);
    e = model_step(4'b1010);
    total++;
    if (err !== e || bit_cnt !== 6'd0 || m_valid !== 1'b0 || m_data !== '0) begin
      bad++;
      $display("FAIL clear_at_30: err=%b cnt=%0d valid=%b, want 0 0 0", err, bit_cnt, m_valid);
    end
  endtask

  task automatic test_commit_at_last();
    bit e;
    m_ready = 1'b1;
    load_random(W - 1);
    press(4'b0101);
    e = model_step(4'b0101);
    total++;
    if (err !== 1'b1 || e !== 1'b1 || bit_cnt !== 6'd48 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL commit_at_last: err=%b cnt=%0d valid=%b, want 1 48 0", err, bit_cnt, m_valid);
    end
    press(4'b0100);
    void'(model_step(4'b0100));
    total++;
    if (m_valid !== 1'b1 || m_data !== m_word) begin
      bad++;
      $display("FAIL commit_after_last: valid=%b data=%h, want 1 %h", m_valid, m_data, m_word);
    end
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset_hold();
    load_random(12);
    @(negedge clk);
    rst = 1'b1;
    btn = 4'b0010;
    repeat (2) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || bit_cnt !== 6'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL mid_load_reset: valid=%b data=%h cnt=%0d err=%b, want all zero", m_valid, m_data, bit_cnt, err);
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bit_cnt !== 6'd0 || err !== 1'b0) begin
        bad++;
        $display("FAIL held_btn[%0d]: cnt=%0d err=%b, want 0 0", k, bit_cnt, err);
      end
    end
    btn = '0;
    repeat (3) @(negedge clk);
    press(4'b0010);
    void'(model_step(4'b0010));
    total++;
    if (bit_cnt !== 6'(m_cnt) || bit_cnt !== 6'd1) begin
      bad++;
      $display("FAIL repress: cnt=%0d, want 1", bit_cnt);
    end
    press(4'b1000);
    void'(model_step(4'b1000));
  endtask

  task automatic test_random();
    logic [3:0] m;
    int         r;
    bit         e;
    m_ready = 1'b1;
    load_random(40);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 39);
      if (r < 17)      m = 4'b0001;
      else if (r < 34) m = 4'b0010;
      else if (r < 37) m = 4'b0100;
      else if (r < 38) m = 4'b0011;
      else if (r < 39) m = 4'b0110;
      else             m = 4'b1000;
      press(m);
      e = model_step(m);
      total++;
      if (err !== e || bit_cnt !== 6'(m_cnt) || m_valid !== m_send || m_data !== (m_send ? m_word : '0)) begin
        bad++;
        $display("FAIL random[%0d] mask=%b: err=%b cnt=%0d valid=%b data=%h, want %b %0d %b %h",
                 i, m, err, bit_cnt, m_valid, m_data, e, m_cnt, m_send, m_send ? m_word : '0);
      end
      if (m_send) model_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_word();
    test_early_commit();
    test_overflow_hold();
    test_pair_and_clear();
    test_commit_at_last();
    test_reset_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
